// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply (radix-2 Booth) / restoring divide into private hi/lo.
// Latency: WIDTH+1 edges from the accepted start to the done pulse; divide-by-zero finishes after 1 edge.
// Backpressure: start is only sampled while busy=0; requests while busy, or on the done edge, are dropped.
//
// Ports:
//   clk, reset (async, active-high)  - clock and reset
//   start, op (0=mul, 1=div), a, b   - request and operands, latched on the accepting edge
//   op_unsigned                      - only when MDU_UNSIGNED_EN is defined: unsigned operation
//   hi, lo                           - mul: product high/low half; div: remainder/quotient
//   busy, done, div_zero             - status; div_zero rises with done and holds until the next start
// Optional feature macro: MDU_UNSIGNED_EN.

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
`ifdef MDU_UNSIGNED_EN
  input  logic             op_unsigned,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Two guard bits above WIDTH: one for the zero-extended unsigned operand,
  // one so Booth partial sums and restoring-divide trial differences never overflow.
  localparam int AW = WIDTH + 2;

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [AW-1:0]    acc_hi;     // mul: upper partial product; div: partial remainder
  logic [AW-1:0]    mcand;      // mul: extended multiplicand; div: divisor magnitude
  logic [WIDTH-1:0] acc_lo;     // mul: multiplier / low product; div: dividend / quotient
  logic             q_m1;       // Booth q(-1) bit
  logic             op_r, uns_r, a_neg, b_neg, dz_r;

  logic             uns_in, dz_in, last_iter, div_ok;
  logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;
  logic [AW-1:0]    booth_sum, rem_sh, rem_try;

`ifdef MDU_UNSIGNED_EN
  assign uns_in = op_unsigned;
`else
  assign uns_in = 1'b0;
`endif

  assign dz_in     = op && (b == '0);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));
  // Magnitudes; the most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  assign a_mag     = (!uns_in && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (!uns_in && b[WIDTH-1]) ? -b : b;

  // Next state and status
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (start) state_nxt = dz_in ? FINISH : RUN;
      RUN:     if (last_iter) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // One iteration of each algorithm
  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q_m1})
      2'b01:   booth_sum = acc_hi + mcand;
      2'b10:   booth_sum = acc_hi - mcand;
      default: booth_sum = acc_hi;
    endcase
    rem_sh  = {acc_hi[AW-2:0], acc_lo[WIDTH-1]};
    rem_try = rem_sh - mcand;
    div_ok  = !rem_try[AW-1];
  end

  // Result formatting at FINISH
  always_comb begin
    res_hi = acc_hi[WIDTH-1:0];
    res_lo = acc_lo;
    if (op_r) begin
      if (!uns_r) begin
        if (a_neg ^ b_neg) res_lo = -acc_lo;
        if (a_neg)         res_hi = -acc_hi[WIDTH-1:0];
      end
    end else if (uns_r && q_m1) begin
      // Final Booth step of the zero-extended (WIDTH+1)-bit multiplier: its top
      // bit pair is (0, b[WIDTH-1]), i.e. add the multiplicand at weight 2^WIDTH.
      res_hi = acc_hi[WIDTH-1:0] + mcand[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      mcand    <= '0;
      q_m1     <= 1'b0;
      op_r     <= 1'b0;
      uns_r    <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      dz_r     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r     <= op;
            uns_r    <= uns_in;
            a_neg    <= !uns_in && a[WIDTH-1];
            b_neg    <= !uns_in && b[WIDTH-1];
            dz_r     <= dz_in;
            div_zero <= 1'b0;
            cnt      <= '0;
            acc_hi   <= '0;
            q_m1     <= 1'b0;
            if (op) begin
              mcand  <= {2'b00, b_mag};
              acc_lo <= a_mag;
            end else begin
              mcand  <= uns_in ? {2'b00, a} : {{2{a[WIDTH-1]}}, a};
              acc_lo <= b;
            end
          end
        end
        RUN: begin
          cnt <= cnt + CNT_W'(1);
          if (op_r) begin
            acc_hi <= div_ok ? rem_try : rem_sh;
            acc_lo <= {acc_lo[WIDTH-2:0], div_ok};
          end else begin
            // Arithmetic right shift of {sum, multiplier, q(-1)}
            acc_hi <= {booth_sum[AW-1], booth_sum[AW-1:1]};
            acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
            q_m1   <= acc_lo[0];
          end
        end
        FINISH: begin
          done <= 1'b1;
          if (dz_r) begin
            div_zero <= 1'b1;
          end else begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, op, op_unsigned;
  logic [W-1:0] a, b, hi, lo;
  logic         busy, done, div_zero;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t         sb_q[$];
  exp_t         mon_e;
  int           cyc = 0;
  int           n_pass = 0;
  int           n_tot = 0;
  logic [W-1:0] hi_m = '0;
  logic [W-1:0] lo_m = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(rst),
    .start(start),
    .op(op),
`ifdef MDU_UNSIGNED_EN
    .op_unsigned(op_unsigned),
`endif
    .a(a),
    .b(b),
    .hi(hi),
    .lo(lo),
    .busy(busy),
    .done(done),
    .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("hi", {32'b0, hi}, {32'b0, mon_e.hi});
        chk("lo", {32'b0, lo}, {32'b0, mon_e.lo});
        chk("div_zero", {63'b0, div_zero}, {63'b0, mon_e.dz});
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("busy_at_done", {63'b0, busy}, 64'd0);
      end
    end
  end

  // Drive one request at the next falling edge and push the reference result.
  task automatic issue(input logic o, input logic [W-1:0] x, input logic [W-1:0] y, input logic u);
    exp_t         e;
    logic [63:0]  p;
    longint       sa, sy, qq, rr;
    @(negedge clk);
    op = o; a = x; b = y; op_unsigned = u; start = 1'b1;
    e.dz  = 1'b0;
    e.cyc = cyc + W + 2;
    if (!o) begin
      if (u) p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
      else begin
        sa = longint'($signed(x));
        sy = longint'($signed(y));
        p  = sa * sy;
      end
      hi_m = p[2*W-1:W];
      lo_m = p[W-1:0];
    end else if (y == '0) begin
      e.dz  = 1'b1;
      e.cyc = cyc + 2;
    end else if (u) begin
      hi_m = x % y;
      lo_m = x / y;
    end else begin
      sa = longint'($signed(x));
      sy = longint'($signed(y));
      qq = sa / sy;
      rr = sa % sy;
      hi_m = rr[W-1:0];
      lo_m = qq[W-1:0];
    end
    e.hi = hi_m;
    e.lo = lo_m;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    chk("div_zero_cleared", {63'b0, div_zero}, 64'd0);
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", 64'(sb_q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom % 6)
      0:       v = '0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = W'($urandom % 16);
      default: v = W'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int busy_cnt;
    logic u;
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; op_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_hi", {32'b0, hi}, 64'd0);
    chk("reset_lo", {32'b0, lo}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);
    chk("reset_done", {63'b0, done}, 64'd0);
    chk("reset_div_zero", {63'b0, div_zero}, 64'd0);
    rst = 1'b0;

    // -3 * 7 with busy span
    issue(1'b0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (busy) busy_cnt++;
      if (i < 31) @(negedge clk);
    end
    chk("busy_cycles", 64'(busy_cnt), 64'd32);
    drain();
    chk("mul_m3x7_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    chk("mul_m3x7_lo", {32'b0, lo}, 64'hFFFF_FFEB);

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    drain();
    chk("div_m7d2_lo", {32'b0, lo}, 64'hFFFF_FFFD);
    chk("div_m7d2_hi", {32'b0, hi}, 64'hFFFF_FFFF);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    drain();
    chk("div_min_m1_lo", {32'b0, lo}, 64'h8000_0000);
    chk("div_min_m1_hi", {32'b0, hi}, 64'h0);

    // Divide by zero keeps hi/lo
    issue(1'b1, 32'd95, 32'd10, 1'b0);
    drain();
    issue(1'b1, 32'd10, 32'd0, 1'b0);
    drain();
    chk("dz_hi_kept", {32'b0, hi}, 64'd5);
    chk("dz_lo_kept", {32'b0, lo}, 64'd9);
    chk("dz_flag_held", {63'b0, div_zero}, 64'd1);
    issue(1'b0, 32'd3, 32'd3, 1'b0);
    drain();

    // Starts while busy and on the done edge are ignored
    issue(1'b0, 32'd4, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1; op = 1'b1; a = W'($urandom); b = W'($urandom);
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    start = 1'b1; op = 1'b1; a = 32'd99; b = 32'd7;
    issue(1'b0, 32'd6, 32'd7, 1'b0);
    drain();

    // Reset in the middle of a divide
    issue(1'b1, 32'h1234_5678, 32'd3, 1'b0);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_hi", {32'b0, hi}, 64'd0);
    chk("midrst_lo", {32'b0, lo}, 64'd0);
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    sb_q.delete();
    hi_m = '0;
    lo_m = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);

    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    drain();
    chk("mul_minmin_hi", {32'b0, hi}, 64'h4000_0000);
    chk("mul_minmin_lo", {32'b0, lo}, 64'h0);

`ifdef MDU_UNSIGNED_EN
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    drain();
    chk("umul_hi", {32'b0, hi}, 64'hFFFF_FFFE);
    chk("umul_lo", {32'b0, lo}, 64'h1);
`endif

    // Randomised mix against the reference model
    for (int n = 0; n < 40; n++) begin
`ifdef MDU_UNSIGNED_EN
      u = 1'($urandom % 2);
`else
      u = 1'b0;
`endif
      issue(1'($urandom % 2), pick(), pick(), u);
      drain();
    end

    chk("queue_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
